// File: rtl/banked_memory.sv
// Burst-capable word memory built from independent byte-lane banks.
// A single request FSM sequences read/write beats with configurable per-beat wait cycles.
module banked_memory #(
  parameter int LANES      = 4,
  parameter int LANE_W     = 8,
  parameter int DEPTH      = 256,
  parameter int BURST_BITS = 2,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reqValid,
  output logic                      reqReady,
  input  logic [$clog2(DEPTH)-1:0]  reqAddr,
  input  logic                      reqWr,
  input  logic [BURST_BITS-1:0]     reqBurstLen,
  input  logic                      wdValid,
  output logic                      wdReady,
  input  logic [LANES*LANE_W-1:0]   wdData,
  input  logic [LANES-1:0]          wdStrb,
  output logic                      rspValid,
  output logic [LANES*LANE_W-1:0]   rspData,
  output logic                      rspLast,
  output logic                      busy
);

  localparam int W       = LANES * LANE_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CW      = $clog2(LAT_MAX + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_LATENCY - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP
  } state_t;

  state_t                state;
  logic [AW-1:0]         addr;
  logic [BURST_BITS-1:0] beatsLeft;
  logic [CW-1:0]         cnt;
  logic [W-1:0]          rdWord;
  logic                  wrFire;

  // reqReady is gated by reset directly so it drops the instant reset rises
  assign reqReady = (state == IDLE) && !reset;
  assign wdReady  = (state == WR_DATA);
  assign busy     = (state != IDLE);
  assign wrFire   = wdReady && wdValid;

  // Bank contents are never reset so data survives an aborted burst
  for (genvar i = 0; i < LANES; i++) begin : g_bank
    logic [LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wrFire && wdStrb[i]) mem[addr] <= wdData[i*LANE_W +: LANE_W];
    end

    assign rdWord[i*LANE_W +: LANE_W] = mem[addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      beatsLeft <= '0;
      cnt       <= '0;
      rspValid  <= 1'b0;
      rspLast   <= 1'b0;
      rspData   <= '0;
    end else begin
      rspValid <= 1'b0;
      rspLast  <= 1'b0;
      rspData  <= '0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            addr      <= reqAddr;
            beatsLeft <= reqBurstLen;
            cnt       <= '0;
            state     <= reqWr ? WR_DATA : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt == RD_LAST) begin
            cnt      <= '0;
            state    <= RD_RESP;
            rspValid <= 1'b1;
            rspLast  <= (beatsLeft == '0);
            rspData  <= rdWord;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_RESP: begin
          if (beatsLeft == '0) begin
            state <= IDLE;
          end else begin
            addr      <= addr + 1'b1;
            beatsLeft <= beatsLeft - 1'b1;
            state     <= RD_WAIT;
          end
        end
        WR_DATA: begin
          if (wdValid) begin
            cnt   <= '0;
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (cnt == WR_LAST) begin
            cnt <= '0;
            if (beatsLeft == '0) begin
              state    <= WR_RESP;
              rspValid <= 1'b1;
              rspLast  <= 1'b1;
            end else begin
              addr      <= addr + 1'b1;
              beatsLeft <= beatsLeft - 1'b1;
              state     <= WR_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_memory.sv
// Randomized scoreboard bench for banked_memory with a word-array reference model.
module tb_banked_memory;
  localparam int LANES      = 4;
  localparam int LANE_W     = 8;
  localparam int DEPTH      = 256;
  localparam int BURST_BITS = 2;
  localparam int RD_LATENCY = 2;
  localparam int WR_LATENCY = 2;
  localparam int W          = LANES * LANE_W;
  localparam int AW         = $clog2(DEPTH);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  reqValid = 1'b0;
  logic                  reqReady;
  logic [AW-1:0]         reqAddr = '0;
  logic                  reqWr = 1'b0;
  logic [BURST_BITS-1:0] reqBurstLen = '0;
  logic                  wdValid = 1'b0;
  logic                  wdReady;
  logic [W-1:0]          wdData = '0;
  logic [LANES-1:0]      wdStrb = '0;
  logic                  rspValid;
  logic [W-1:0]          rspData;
  logic                  rspLast;
  logic                  busy;

  banked_memory #(
    .LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .BURST_BITS(BURST_BITS),
    .RD_LATENCY(RD_LATENCY), .WR_LATENCY(WR_LATENCY)
  ) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqWr(reqWr),
    .reqBurstLen(reqBurstLen),
    .wdValid(wdValid), .wdReady(wdReady), .wdData(wdData), .wdStrb(wdStrb),
    .rspValid(rspValid), .rspData(rspData), .rspLast(rspLast), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int unsigned  at;
  } rsp_t;

  rsp_t         sbq[$];
  rsp_t         mon_e;
  logic [W-1:0] model [DEPTH];
  logic [W-1:0] lastRd = '0;
  int           checks = 0;
  int           errors = 0;

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic abort_run(input string name);
    errors++;
    $display("FAIL %s: bound expired, got no event expected one", name);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (!rspValid) chk_b("lastWithoutValid", rspLast, 1'b0);
      if (rspValid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedRsp: got rspValid=1 data %h expected no response", rspData);
        end else begin
          mon_e = sbq.pop_front();
          chk_w("rspData", rspData, mon_e.data);
          chk_b("rspLast", rspLast, mon_e.last);
          chk_i("rspCycle", cyc, mon_e.at);
          lastRd = rspData;
        end
      end
    end
  end

  task automatic do_req(input logic wr, input int addr, input int len, output int unsigned e0);
    int n;
    n = 0;
    @(negedge clk);
    reqValid    = 1'b1;
    reqWr       = wr;
    reqAddr     = AW'(addr);
    reqBurstLen = BURST_BITS'(len);
    while (!reqReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) abort_run("reqAccept");
    @(posedge clk);
    #1;
    e0 = cyc;
    reqValid = 1'b0;
  endtask

  task automatic rd_burst(input int addr, input int len, output int unsigned e0);
    rsp_t e;
    do_req(1'b0, addr, len, e0);
    for (int i = 0; i <= len; i++) begin
      e.data = model[(addr + i) % DEPTH];
      e.last = (i == len);
      e.at   = e0 + i * (RD_LATENCY + 1) + RD_LATENCY;
      sbq.push_back(e);
    end
  endtask

  task automatic wr_beat(input int a, input logic [W-1:0] d, input logic [LANES-1:0] s,
                         input int gapLen, output int unsigned ew);
    int n;
    n = 0;
    @(negedge clk);
    while (!wdReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wdReady) abort_run("wdReady");
    for (int g = 0; g < gapLen; g++) begin
      chk_b("gapWdReady", wdReady, 1'b1);
      chk_b("gapBusy", busy, 1'b1);
      @(negedge clk);
    end
    wdValid = 1'b1;
    wdData  = d;
    wdStrb  = s;
    @(posedge clk);
    #1;
    ew = cyc;
    wdValid = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (s[l]) model[a % DEPTH][l*LANE_W +: LANE_W] = d[l*LANE_W +: LANE_W];
  endtask

  task automatic wr_burst(input int addr, input int len, input logic [W-1:0] d [4],
                          input logic [LANES-1:0] s [4], input int gapBeat, input int gapLen);
    int unsigned e0, ew;
    rsp_t e;
    do_req(1'b1, addr, len, e0);
    for (int i = 0; i <= len; i++)
      wr_beat(addr + i, d[i], s[i], (i == gapBeat) ? gapLen : 0, ew);
    e.data = '0;
    e.last = 1'b1;
    e.at   = ew + WR_LATENCY;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || busy) abort_run("drain");
  endtask

  logic [W-1:0]     dv [4];
  logic [LANES-1:0] sv [4];
  logic [LANES-1:0] sF [4];
  int unsigned      e0a, e0b, ew;
  int               ra, rl;

  initial begin
    for (int i = 0; i < 4; i++) sF[i] = '1;

    repeat (3) @(negedge clk);
    #1;
    chk_b("rstReqReady", reqReady, 1'b0);
    chk_b("rstWdReady", wdReady, 1'b0);
    chk_b("rstRspValid", rspValid, 1'b0);
    chk_b("rstRspLast", rspLast, 1'b0);
    chk_w("rstRspData", rspData, '0);
    chk_b("rstBusy", busy, 1'b0);
    reset = 1'b0;
    #1;
    chk_b("relReqReady", reqReady, 1'b1);

    // Fill every word so the model and the banks start in agreement
    for (int k = 0; k < DEPTH / 4; k++) begin
      for (int i = 0; i < 4; i++) dv[i] = W'($urandom);
      wr_burst(k * 4, 3, dv, sF, -1, 0);
    end
    drain();

    dv[0] = 32'hDDCCBBAA;
    wr_burst(16, 0, dv, sF, -1, 0);
    rd_burst(16, 0, e0a);
    drain();
    chk_w("fullWordRead", lastRd, 32'hDDCCBBAA);

    dv[0] = 32'h11223344;
    sv[0] = 4'h5;
    wr_burst(16, 0, dv, sv, -1, 0);
    rd_burst(16, 0, e0a);
    drain();
    chk_w("strobeMerge", lastRd, 32'hDD22BB44);

    for (int i = 0; i < 4; i++) dv[i] = W'(i + 1);
    wr_burst(254, 3, dv, sF, -1, 0);
    rd_burst(254, 3, e0a);
    drain();
    chk_w("wrapLastBeat", lastRd, 32'h4);
    chk_w("wrapAddr0", model[0], 32'h3);

    for (int i = 0; i < 4; i++) dv[i] = W'($urandom);
    wr_burst(64, 1, dv, sF, 1, 5);
    rd_burst(64, 1, e0a);
    drain();

    // Reset during the third beat of a four-beat write
    for (int i = 0; i < 4; i++) dv[i] = W'($urandom);
    do_req(1'b1, 128, 3, e0a);
    wr_beat(128, dv[0], 4'hF, 0, ew);
    wr_beat(129, dv[1], 4'hF, 0, ew);
    @(negedge clk);
    while (!wdReady && (cyc - ew) < 20) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_b("midRstReqReady", reqReady, 1'b0);
    chk_b("midRstWdReady", wdReady, 1'b0);
    chk_b("midRstRspValid", rspValid, 1'b0);
    chk_b("midRstRspLast", rspLast, 1'b0);
    chk_w("midRstRspData", rspData, '0);
    chk_b("midRstBusy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_b("midRelReqReady", reqReady, 1'b1);
    rd_burst(128, 3, e0a);
    drain();

    // Back-to-back reads: second must land on the first IDLE cycle
    rd_burst(32, 3, e0a);
    rd_burst(48, 0, e0b);
    chk_i("heldReqAccept", e0b, e0a + 4 * (RD_LATENCY + 1) + 1);
    drain();

    for (int t = 0; t < 40; t++) begin
      ra = $urandom_range(0, DEPTH - 1);
      rl = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) begin
          dv[i] = W'($urandom);
          sv[i] = LANES'($urandom_range(0, 15));
        end
        wr_burst(ra, rl, dv, sv, $urandom_range(0, rl), $urandom_range(0, 2));
      end else begin
        rd_burst(ra, rl, e0a);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
